fp_norm_pack: RTL and testbench

- Final stage of the single-precision FP add/sub datapath.
- Sits directly downstream of the mantissa add/subtract stage and consumes its raw sum, exponent and sign.
- Normalizes the sum iteratively, one bit shift per cycle, then packs the IEEE-754 word and raises overflow, underflow and zero flags.
- Rounding is truncation (round-toward-zero); there are no guard or sticky bits.

---
 rtl/fp_norm_pack.sv | 158 +++++++++++++++
 tb/tb_fp_norm_pack.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack.sv
// Final FP add/sub stage: iterative one-bit-per-cycle normalization of the raw
// mantissa sum, truncating pack to IEEE-754 layout, overflow/underflow/zero flags.
module fp_norm_pack #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+1:0]         in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     zero
);
    localparam int unsigned M_W = MAN_W + 2;
    localparam int unsigned E_W = EXP_W + 1;
    localparam int unsigned R_W = 1 + EXP_W + MAN_W;
    localparam logic [E_W-1:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [E_W-1:0] E_ONE = E_W'(1);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic [E_W-1:0]   e_q, e_d;
    logic [M_W-1:0]   m_q, m_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [R_W-1:0]   out_result_q, out_result_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             zero_q, zero_d;

    // Next-state and datapath; DONE spends one cycle packing before out_valid rises
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        e_d          = e_q;
        m_d          = m_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        zero_d       = zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = in_sign;
                    e_d     = {1'b0, in_exp};
                    m_d     = in_mant;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (m_q == '0) begin
                    s_d     = 1'b0;
                    e_d     = '0;
                    state_d = DONE;
                end else if (m_q[MAN_W+1]) begin
                    m_d = m_q >> 1;
                    e_d = e_q + E_ONE;
                    if (e_d == E_MAX) begin
                        m_d   = '0;
                        ovf_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (m_q[MAN_W]) begin
                    state_d = DONE;
                end else if (e_q <= E_ONE) begin
                    e_d     = '0;
                    m_d     = '0;
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                m_d = m_q << 1;
                e_d = e_q - E_ONE;
                if (m_d[MAN_W]) begin
                    state_d = DONE;
                end else if (e_d == E_ONE) begin
                    e_d     = '0;
                    m_d     = '0;
                    unf_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = {s_q, e_q[EXP_W-1:0], m_q[MAN_W-1:0]};
                    overflow_d   = ovf_q;
                    underflow_d  = unf_q;
                    zero_d       = (e_q[EXP_W-1:0] == '0) && (m_q[MAN_W-1:0] == '0);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= 1'b0;
            e_q          <= '0;
            m_q          <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            e_q          <= e_d;
            m_q          <= m_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            zero_q       <= zero_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack: directed corner cases plus random sums
// checked against a leading-one based arithmetic reference model.
module tb_fp_norm_pack;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        overflow;
    logic        underflow;
    logic        zero;

    int n_assert = 0;
    int n_fail   = 0;

    fp_norm_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Value-level model: locate the leading one, derive exponent and shift count
    function automatic void model(input logic s, input int e, input logic [24:0] m,
                                  output logic [31:0] r, output logic ovf,
                                  output logic unf, output logic zr, output int lat);
        int p;
        int k;
        logic [24:0] mm;
        r = 32'h0; ovf = 1'b0; unf = 1'b0; zr = 1'b0; lat = 2; p = -1;
        for (int i = 0; i < 25; i++) if (m[i]) p = i;
        if (p < 0) begin
            zr = 1'b1;
        end else if (p == 24) begin
            if (e + 1 >= 255) begin
                r = {s, 8'hFF, 23'h0};
                ovf = 1'b1;
            end else begin
                mm = m >> 1;
                r = {s, 8'(e + 1), mm[22:0]};
            end
        end else if (p == 23) begin
            r = {s, 8'(e), m[22:0]};
        end else begin
            k = 23 - p;
            if (k > e - 1) begin
                r   = {s, 31'h0};
                unf = 1'b1;
                zr  = 1'b1;
                lat = (e <= 1) ? 2 : 2 + (e - 1);
            end else begin
                mm  = m << k;
                r   = {s, 8'(e - k), mm[22:0]};
                lat = 2 + k;
            end
        end
        if (!unf && !ovf && p >= 0) zr = (r[30:0] == 31'h0);
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input int hold);
        logic [31:0] er;
        logic eo, eu, ez;
        int el;
        int w;
        int lat;
        model(s, int'(e), m, er, eo, eu, ez, el);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        chk({tag, ".latency"}, 32'(lat), 32'(el));
        chk({tag, ".result"}, out_result, er);
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, out_result, er);
            chk({tag, ".hold_flags"}, 32'({overflow, underflow, zero}), 32'({eo, eu, ez}));
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [24:0] rm;
        logic [7:0]  re;
        int          p;
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_result", out_result, 32'h0);
        chk("rst.flags", 32'({overflow, underflow, zero}), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        run_op("carry",    1'b0, 8'd127, 25'h1000000, 0);
        chk("carry.abs", out_result, 32'h40000000);
        run_op("cancel",   1'b1, 8'd130, 25'h0000000, 0);
        run_op("longsh",   1'b0, 8'd127, 25'h0000001, 0);
        run_op("ovf",      1'b0, 8'd254, 25'h1800000, 0);
        run_op("unf",      1'b1, 8'd3,   25'h0000010, 0);
        run_op("norm",     1'b1, 8'd200, 25'h0ABCDEF, 0);
        run_op("backpr",   1'b0, 8'd100, 25'h0012345, 5);

        // Abort during the 10th SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 25'h0000001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("abort.no_result", 32'(out_valid), 32'd0);
        run_op("post_abort", 1'b0, 8'd127, 25'h1000000, 0);

        for (int t = 0; t < 40; t++) begin
            p  = int'($urandom_range(0, 25));
            rm = 25'($urandom);
            if (p == 25) rm = '0;
            else rm = (rm & ((25'd1 << p) - 25'd1)) | (25'd1 << p);
            if ($urandom_range(0, 3) == 0) re = 8'($urandom_range(0, 6));
            else if ($urandom_range(0, 5) == 0) re = 8'd254;
            else re = 8'($urandom_range(1, 254));
            run_op($sformatf("rnd%0d", t), 1'($urandom), re, rm, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
